// File: rtl/alu_seg_disp_pkg.sv
// Shared types and constants for the ALU result display stage (alu_seg_disp).
// Segment vectors are ordered a,b,c,d,e,f,g,dp from bit7 down to bit0, active low.
package alu_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_ERR
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  // Flag digit: dp always lit, d marks carry, g marks overflow unless blinked off.
  function automatic logic [7:0] flag_glyph(input logic car, input logic of,
                                            input logic g_off);
    logic [7:0] s;
    s         = SEG_BLANK;
    s[SEG_DP] = 1'b0;
    s[SEG_D]  = ~car;
    s[SEG_G]  = ~(of & ~g_off);
    return s;
  endfunction

endpackage

// File: rtl/alu_seg_disp_if.sv
// Upstream ALU handshake plus the two seven-segment outputs of alu_seg_disp.
interface alu_seg_disp_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] res;
  logic       car;
  logic       of;
  logic [2:0] ctrl;
  logic       clr;
  logic [7:0] seg0;
  logic [7:0] seg1;

  modport master (
    output in_valid, res, car, of, ctrl, clr,
    input  in_ready, seg0, seg1
  );

  modport slave (
    input  in_valid, res, car, of, ctrl, clr,
    output in_ready, seg0, seg1
  );

endinterface

// File: rtl/alu_seg_disp_hex7seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder; dp is driven off.
module hex7seg (
  input  logic [3:0] val_i,
  output logic [7:0] seg_o
);

  always_comb begin
    unique case (val_i)
      4'h0: seg_o = 8'h03;
      4'h1: seg_o = 8'h9F;
      4'h2: seg_o = 8'h25;
      4'h3: seg_o = 8'h0D;
      4'h4: seg_o = 8'h99;
      4'h5: seg_o = 8'h49;
      4'h6: seg_o = 8'h41;
      4'h7: seg_o = 8'h1F;
      4'h8: seg_o = 8'h01;
      4'h9: seg_o = 8'h09;
      4'hA: seg_o = 8'h11;
      4'hB: seg_o = 8'hC1;
      4'hC: seg_o = 8'h63;
      4'hD: seg_o = 8'h85;
      4'hE: seg_o = 8'h61;
      default: seg_o = 8'h71;
    endcase
  end

endmodule

// File: rtl/alu_seg_disp.sv
// ALU result display stage: captures res/car/of/ctrl and drives result and flag digits.
// Optional ALU_SEG_SIGNED_EN shows add/sub results as signed magnitude with a sign dp.
module alu_seg_disp
  import alu_seg_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 5_000_000
) (
  input  logic           clk,
  input  logic           rst,
  alu_seg_disp_if.slave  bus
);

  localparam int unsigned    CNT_W   = $clog2(BLINK_HALF);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF - 1);

  state_e           state_q, state_d;
  logic [3:0]       res_q;
  logic             car_q;
  logic             of_q;
  logic [2:0]       ctrl_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [7:0]       seg0_q, seg0_d;
  logic [7:0]       seg1_q, seg1_d;

  logic             capture;
  logic [3:0]       dec_val;
  logic [7:0]       dec_seg;
  logic [7:0]       res_glyph;

  assign bus.in_ready = !bus.clr && (state_q != ST_LOAD);
  assign capture      = bus.in_valid && bus.in_ready;
  assign bus.seg0     = seg0_q;
  assign bus.seg1     = seg1_q;

`ifdef ALU_SEG_SIGNED_EN
  logic neg_mode;
  assign neg_mode  = ((ctrl_q == OP_ADD) || (ctrl_q == OP_SUB)) && res_q[3];
  // 4'b1000 negates to itself, which reads correctly as magnitude 8.
  assign dec_val   = neg_mode ? (4'd0 - res_q) : res_q;
  assign res_glyph = dec_seg & {7'h7F, ~neg_mode};
`else
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_q;
  assign dec_val     = res_q;
  assign res_glyph   = dec_seg;
`endif

  hex7seg u_hex7seg (
    .val_i (dec_val),
    .seg_o (dec_seg)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      car_q   <= 1'b0;
      of_q    <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      seg0_q  <= SEG_BLANK;
      seg1_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
      if (capture) begin
        res_q  <= bus.res;
        car_q  <= bus.car;
        of_q   <= bus.of;
        ctrl_q <= bus.ctrl;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:                   state_d = of_q ? ST_ERR : ST_SHOW;
        ST_IDLE, ST_SHOW, ST_ERR:  if (bus.clr) state_d = ST_IDLE;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  // Blink timer only runs while staying in ERR; any entry starts lit at count 0.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b1;
    if ((state_q == ST_ERR) && (state_d == ST_ERR)) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_comb begin
    seg0_d = seg0_q;
    seg1_d = seg1_q;
    if (!capture) begin
      case (state_q)
        ST_LOAD: begin
          seg0_d = res_glyph;
          seg1_d = flag_glyph(car_q, of_q, 1'b0);
        end
        ST_ERR: begin
          if (bus.clr) begin
            seg0_d = SEG_BLANK;
            seg1_d = SEG_BLANK;
          end else begin
            seg0_d = phase_d ? res_glyph : SEG_BLANK;
            seg1_d = flag_glyph(car_q, of_q, ~phase_d);
          end
        end
        default: begin
          if (bus.clr) begin
            seg0_d = SEG_BLANK;
            seg1_d = SEG_BLANK;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seg_disp.sv
// Directed self-checking bench for alu_seg_disp with a short blink period.
module tb_alu_seg_disp;
  import alu_seg_pkg::*;

  typedef struct {
    logic [3:0] res;
    logic       car;
    logic       of;
    logic [2:0] ctrl;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[10];

  alu_seg_disp_if bus ();

  alu_seg_disp #(.BLINK_HALF(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic c, input logic o, input logic [2:0] op);
    bus.in_valid = 1'b1;
    bus.res      = r;
    bus.car      = c;
    bus.of       = o;
    bus.ctrl     = op;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.res, v.car, v.of, v.ctrl);
    #1;
    check($sformatf("v%0d_ready_before", idx), 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    #1;
    check($sformatf("v%0d_ready_load", idx), 32'(bus.in_ready), 32'd0);
    check($sformatf("v%0d_state_load", idx), 32'(dut.state_q), 32'(ST_LOAD));
    step();
    check($sformatf("v%0d_seg0", idx), 32'(bus.seg0), 32'(v.e0));
    check($sformatf("v%0d_seg1", idx), 32'(bus.seg1), 32'(v.e1));
    check($sformatf("v%0d_ready_after", idx), 32'(bus.in_ready), 32'd1);
    check($sformatf("v%0d_state", idx), 32'(dut.state_q), 32'(ST_SHOW));
  endtask

  // Checks n ERR samples where phase is lit for the first 4, dark for the next 4, ...
  task automatic check_blink(input string tag, input int n, input logic [7:0] lit0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      if (((i / 4) % 2) == 0) begin
        check($sformatf("%s_%0d_seg0", tag, i), 32'(bus.seg0), 32'(lit0));
        check($sformatf("%s_%0d_seg1", tag, i), 32'(bus.seg1), 32'h0FC);
      end else begin
        check($sformatf("%s_%0d_seg0", tag, i), 32'(bus.seg0), 32'h0FF);
        check($sformatf("%s_%0d_seg1", tag, i), 32'(bus.seg1), 32'h0FE);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{4'h1, 1'b1, 1'b0, OP_ADD, 8'h9F, 8'hEE};
    vecs[1] = '{4'h0, 1'b0, 1'b0, OP_NOT, 8'h03, 8'hFE};
    vecs[2] = '{4'h8, 1'b0, 1'b0, OP_AND, 8'h01, 8'hFE};
    vecs[3] = '{4'h9, 1'b1, 1'b0, OP_OR,  8'h09, 8'hEE};
    vecs[4] = '{4'hF, 1'b0, 1'b0, OP_XOR, 8'h71, 8'hFE};
    vecs[5] = '{4'hD, 1'b0, 1'b0, OP_AND, 8'h85, 8'hFE};
    vecs[6] = '{4'hA, 1'b1, 1'b0, OP_LT,  8'h11, 8'hEE};
    vecs[7] = '{4'h3, 1'b0, 1'b0, OP_ADD, 8'h0D, 8'hFE};
`ifdef ALU_SEG_SIGNED_EN
    vecs[8] = '{4'hD, 1'b0, 1'b0, OP_SUB, 8'h0C, 8'hFE};
    vecs[9] = '{4'h8, 1'b0, 1'b0, OP_ADD, 8'h00, 8'hFE};
`else
    vecs[8] = '{4'hD, 1'b0, 1'b0, OP_SUB, 8'h85, 8'hFE};
    vecs[9] = '{4'h8, 1'b0, 1'b0, OP_ADD, 8'h01, 8'hFE};
`endif

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.res      = '0;
    bus.car      = 1'b0;
    bus.of       = 1'b0;
    bus.ctrl     = '0;
    bus.clr      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    check("rst_seg0",  32'(bus.seg0), 32'h0FF);
    check("rst_seg1",  32'(bus.seg1), 32'h0FF);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("rst_phase", 32'(dut.phase_q), 32'd1);
    check("rst_cnt",   32'(dut.cnt_q), 32'd0);

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Held in_valid recaptures every other cycle; the last value wins.
    drive(4'h2, 1'b0, 1'b0, OP_OR);
    step();
    bus.res = 4'h5;
    #1;
    check("b2b_ready_load", 32'(bus.in_ready), 32'd0);
    step();
    check("b2b_seg0_first", 32'(bus.seg0), 32'h025);
    check("b2b_ready_show", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    check("b2b_seg0_last", 32'(bus.seg0), 32'h049);

    // clr in SHOW blanks both digits next edge.
    bus.clr = 1'b1;
    #1;
    check("clr_show_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.clr = 1'b0;
    check("clr_show_seg0",  32'(bus.seg0), 32'h0FF);
    check("clr_show_seg1",  32'(bus.seg1), 32'h0FF);
    check("clr_show_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Overflow blink with BLINK_HALF=4.
    drive(4'h9, 1'b0, 1'b1, OP_AND);
    step();
    bus.in_valid = 1'b0;
    step();
    check("err_state", 32'(dut.state_q), 32'(ST_ERR));
    check_blink("blink", 14, 8'h09);

    // Recapture while dark: LOAD holds the display, then blink restarts lit.
    drive(4'hF, 1'b0, 1'b1, OP_AND);
    step();
    bus.in_valid = 1'b0;
    check("recap_state", 32'(dut.state_q), 32'(ST_LOAD));
    check("recap_hold",  32'(bus.seg0), 32'h0FF);
    step();
    check_blink("reblink", 8, 8'h71);

    // Reset during the dark phase.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_err_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("rst_err_seg0",  32'(bus.seg0), 32'h0FF);
    check("rst_err_seg1",  32'(bus.seg1), 32'h0FF);
    check("rst_err_phase", 32'(dut.phase_q), 32'd1);
    check("rst_err_cnt",   32'(dut.cnt_q), 32'd0);
    check("rst_err_res",   32'(dut.res_q), 32'd0);

    // clr and in_valid together in ERR: clr wins, nothing is captured.
    drive(4'h9, 1'b0, 1'b1, OP_AND);
    step();
    bus.in_valid = 1'b0;
    step();
    check("cv_err_state", 32'(dut.state_q), 32'(ST_ERR));
    drive(4'h2, 1'b1, 1'b0, OP_OR);
    bus.clr = 1'b1;
    #1;
    check("cv_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    check("cv_seg0",  32'(bus.seg0), 32'h0FF);
    check("cv_seg1",  32'(bus.seg1), 32'h0FF);
    check("cv_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("cv_res",   32'(dut.res_q), 32'h9);
    step();
    check("cv_seg0_stay", 32'(bus.seg0), 32'h0FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
